// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/result handshake bundle for fp_mul_pipe.
//   in1, in2, round_m, tag_in, act  -> request side (act = valid, in_ready = ready)
//   out, tag_out, ov/un/inv/inexact, done -> result side (done = valid, out_ready = ready)
// slave is the multiplier's view; master is the issue/writeback side.
interface fp_mul_pipe_if #(
   parameter int EW = 8,
   parameter int MW = 23,
   parameter int TW = 4
);
   localparam int W = EW + MW + 1;

   logic [W-1:0]  in1;
   logic [W-1:0]  in2;
   logic [2:0]    round_m;
   logic [TW-1:0] tag_in;
   logic          act;
   logic          in_ready;
   logic [W-1:0]  out;
   logic [TW-1:0] tag_out;
   logic          done;
   logic          out_ready;
   logic          ov;
   logic          un;
   logic          inv;
   logic          inexact;

   modport slave (
      input  in1, in2, round_m, tag_in, act, out_ready,
      output in_ready, out, tag_out, done, ov, un, inv, inexact
   );

   modport master (
      output in1, in2, round_m, tag_in, act, out_ready,
      input  in_ready, out, tag_out, done, ov, un, inv, inexact
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-754 multiplier, generic exponent and
// fraction widths, flush-to-zero on subnormal inputs and outputs.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fp_mul_pipe_if.slave: operands, rounding mode, tag, valid/ready in,
//          result, tag, flags, valid/ready out
// Stage 1 classifies operands and resolves special cases, stage 2 multiplies
// significands, stage 3 normalises, rounds and packs. The whole pipe stalls
// when a result is held and not taken.
// Rounding mode codes: 0 RNe, 1 RZ, 2 RU, 3 RD, 4 RNa; other codes act as RNe.
module fp_mul_pipe #(
   parameter int EW = 8,
   parameter int MW = 23,
   parameter int TW = 4
) (
   input  logic         clk,
   input  logic         rst,
   fp_mul_pipe_if.slave bus
);
   localparam int W  = EW + MW + 1;
   localparam int PW = 2 * MW + 2;

   localparam logic [2:0] RM_RZ  = 3'd1;
   localparam logic [2:0] RM_RU  = 3'd2;
   localparam logic [2:0] RM_RD  = 3'd3;
   localparam logic [2:0] RM_RNA = 3'd4;

   localparam logic signed [EW+1:0] BIAS   = (EW+2)'((1 << (EW - 1)) - 1);
   localparam logic signed [EW+1:0] E_OVF  = (EW+2)'((1 << EW) - 1);
   localparam logic signed [EW+1:0] E_ZERO = '0;
   localparam logic signed [EW+1:0] E_ONE  = (EW+2)'(1);
   localparam logic [EW-1:0] EXP_ONES = '1;
   localparam logic [EW-1:0] EXP_MAXF = {{(EW-1){1'b1}}, 1'b0};
   localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

   logic en;

   // stage 1 registers
   logic                 v1_d, v1_q, sign1_d, sign1_q, sp1_d, sp1_q, inv1_d, inv1_q;
   logic [MW-1:0]        fa1_d, fa1_q, fb1_d, fb1_q;
   logic signed [EW+1:0] exp1_d, exp1_q;
   logic [2:0]           rm1_d, rm1_q;
   logic [TW-1:0]        tag1_d, tag1_q;
   logic [W-1:0]         spres1_d, spres1_q;

   // stage 2 registers
   logic                 v2_d, v2_q, sign2_d, sign2_q, sp2_d, sp2_q, inv2_d, inv2_q;
   logic [PW-1:0]        prod2_d, prod2_q;
   logic signed [EW+1:0] exp2_d, exp2_q;
   logic [2:0]           rm2_d, rm2_q;
   logic [TW-1:0]        tag2_d, tag2_q;
   logic [W-1:0]         spres2_d, spres2_q;

   // stage 3 (output) registers
   logic          done_d, done_q, ov_d, ov_q, un_d, un_q, inv_d, inv_q, inx_d, inx_q;
   logic [W-1:0]  res_d, res_q;
   logic [TW-1:0] tag3_d, tag3_q;

   assign en           = !done_q || bus.out_ready;
   assign bus.in_ready = en;
   assign bus.done     = done_q;
   assign bus.out      = res_q;
   assign bus.tag_out  = tag3_q;
   assign bus.ov       = ov_q;
   assign bus.un       = un_q;
   assign bus.inv      = inv_q;
   assign bus.inexact  = inx_q;

   // ---------------- stage 1: unpack / classify ----------------
   logic [EW-1:0] e1, e2;
   logic [MW-1:0] f1, f2;
   logic          z1, z2, i1, i2, n1, n2, sn1, sn2;

   always_comb begin
      e1  = bus.in1[W-2:MW];
      e2  = bus.in2[W-2:MW];
      f1  = bus.in1[MW-1:0];
      f2  = bus.in2[MW-1:0];
      // exponent zero covers true zeros and flushed subnormals
      z1  = (e1 == '0);
      z2  = (e2 == '0);
      i1  = (e1 == EXP_ONES) && (f1 == '0);
      i2  = (e2 == EXP_ONES) && (f2 == '0);
      n1  = (e1 == EXP_ONES) && (f1 != '0);
      n2  = (e2 == EXP_ONES) && (f2 != '0);
      sn1 = n1 && !f1[MW-1];
      sn2 = n2 && !f2[MW-1];

      v1_d     = bus.act;
      sign1_d  = bus.in1[W-1] ^ bus.in2[W-1];
      fa1_d    = f1;
      fb1_d    = f2;
      exp1_d   = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS;
      rm1_d    = bus.round_m;
      tag1_d   = bus.tag_in;
      sp1_d    = 1'b1;
      inv1_d   = 1'b0;
      spres1_d = QNAN;
      if (n1 || n2) begin
         inv1_d = sn1 || sn2;
      end else if ((i1 && z2) || (z1 && i2)) begin
         inv1_d = 1'b1;
      end else if (i1 || i2) begin
         spres1_d = {sign1_d, EXP_ONES, {MW{1'b0}}};
      end else if (z1 || z2) begin
         spres1_d = {sign1_d, {(W-1){1'b0}}};
      end else begin
         sp1_d = 1'b0;
      end
   end

   // ---------------- stage 2: significand multiply ----------------
   always_comb begin
      v2_d     = v1_q;
      sign2_d  = sign1_q;
      prod2_d  = PW'({1'b1, fa1_q}) * PW'({1'b1, fb1_q});
      exp2_d   = exp1_q;
      rm2_d    = rm1_q;
      tag2_d   = tag1_q;
      sp2_d    = sp1_q;
      inv2_d   = inv1_q;
      spres2_d = spres1_q;
   end

   // ---------------- stage 3: normalise / round / pack ----------------
   logic [MW:0]          mant;
   logic [MW+1:0]        mant_r;
   logic [MW-1:0]        frac_r;
   logic                 g, t, inc, to_inf;
   logic signed [EW+1:0] e_n, e_r;

   always_comb begin
      if (prod2_q[PW-1]) begin
         mant = prod2_q[PW-1:MW+1];
         g    = prod2_q[MW];
         t    = |prod2_q[MW-1:0];
         e_n  = exp2_q + E_ONE;
      end else begin
         mant = prod2_q[PW-2:MW];
         g    = prod2_q[MW-1];
         t    = |prod2_q[MW-2:0];
         e_n  = exp2_q;
      end

      case (rm2_q)
         RM_RZ:   inc = 1'b0;
         RM_RU:   inc = (g || t) && !sign2_q;
         RM_RD:   inc = (g || t) && sign2_q;
         RM_RNA:  inc = g;
         default: inc = g && (t || mant[0]);
      endcase

      // a carry out of the significand means it was all ones: renormalise
      mant_r = {1'b0, mant} + {{(MW+1){1'b0}}, inc};
      e_r    = mant_r[MW+1] ? e_n + E_ONE : e_n;
      frac_r = mant_r[MW+1] ? mant_r[MW:1] : mant_r[MW-1:0];

      // overflow saturates to max finite only when rounding toward zero
      to_inf = !((rm2_q == RM_RZ) || (rm2_q == RM_RU && sign2_q) ||
                 (rm2_q == RM_RD && !sign2_q));

      done_d = v2_q;
      tag3_d = tag2_q;
      ov_d   = 1'b0;
      un_d   = 1'b0;
      inv_d  = 1'b0;
      inx_d  = 1'b0;
      res_d  = {sign2_q, e_r[EW-1:0], frac_r};
      if (sp2_q) begin
         res_d = spres2_q;
         inv_d = inv2_q;
      end else if (e_r >= E_OVF) begin
         ov_d  = 1'b1;
         inx_d = 1'b1;
         res_d = to_inf ? {sign2_q, EXP_ONES, {MW{1'b0}}} : {sign2_q, EXP_MAXF, {MW{1'b1}}};
      end else if (e_r <= E_ZERO) begin
         un_d  = 1'b1;
         inx_d = 1'b1;
         res_d = {sign2_q, {(W-1){1'b0}}};
      end else begin
         inx_d = g || t;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q <= 1'b0;  sign1_q <= 1'b0;  sp1_q <= 1'b0;  inv1_q <= 1'b0;
         fa1_q <= '0;   fb1_q <= '0;      exp1_q <= '0;   rm1_q <= '0;
         tag1_q <= '0;  spres1_q <= '0;
         v2_q <= 1'b0;  sign2_q <= 1'b0;  sp2_q <= 1'b0;  inv2_q <= 1'b0;
         prod2_q <= '0; exp2_q <= '0;     rm2_q <= '0;    tag2_q <= '0;
         spres2_q <= '0;
         done_q <= 1'b0; res_q <= '0; tag3_q <= '0;
         ov_q <= 1'b0;  un_q <= 1'b0;  inv_q <= 1'b0;  inx_q <= 1'b0;
      end else if (en) begin
         v1_q <= v1_d;  sign1_q <= sign1_d;  sp1_q <= sp1_d;  inv1_q <= inv1_d;
         fa1_q <= fa1_d; fb1_q <= fb1_d;     exp1_q <= exp1_d; rm1_q <= rm1_d;
         tag1_q <= tag1_d; spres1_q <= spres1_d;
         v2_q <= v2_d;  sign2_q <= sign2_d;  sp2_q <= sp2_d;  inv2_q <= inv2_d;
         prod2_q <= prod2_d; exp2_q <= exp2_d; rm2_q <= rm2_d; tag2_q <= tag2_d;
         spres2_q <= spres2_d;
         done_q <= done_d;
         // bubbles leave the last result in place
         if (v2_q) begin
            res_q <= res_d;  tag3_q <= tag3_d;
            ov_q <= ov_d;    un_q <= un_d;  inv_q <= inv_d;  inx_q <= inx_d;
         end
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_mul_pipe_if #(.EW(8), .MW(23), .TW(4)) b1 ();
   fp_mul_pipe_if #(.EW(5), .MW(10), .TW(4)) bh ();

   fp_mul_pipe #(.EW(8), .MW(23), .TW(4)) u_dut  (.clk(clk), .rst(rst), .bus(b1));
   fp_mul_pipe #(.EW(5), .MW(10), .TW(4)) u_half (.clk(clk), .rst(rst), .bus(bh));

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_pop = 0;
   logic [39:0] sb_q[$];
   logic        held_vld;
   logic [39:0] held_val;

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, obs, exp);
      end
   endtask

   // {tag, ov, un, inv, inexact, out}
   function automatic logic [39:0] obs1();
      return {b1.tag_out, b1.ov, b1.un, b1.inv, b1.inexact, b1.out};
   endfunction

   // Single-precision reference: exact integer product, then round by
   // comparing the discarded remainder with half an ulp.
   function automatic logic [39:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm, input logic [3:0] tg);
      int ea, eb, e, n, sh;
      longint ma, mb, p, q, rem, half;
      bit s, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, rup;
      logic [31:0] o;
      logic [3:0]  fl;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      nan_a  = (ea == 255) && (a[22:0] != 0);
      nan_b  = (eb == 255) && (b[22:0] != 0);
      snan_a = nan_a && !a[22];
      snan_b = nan_b && !b[22];
      inf_a  = (ea == 255) && (a[22:0] == 0);
      inf_b  = (eb == 255) && (b[22:0] == 0);
      zero_a = (ea == 0);
      zero_b = (eb == 0);
      fl = 4'b0000;
      if (nan_a || nan_b) begin
         o = 32'h7FC00000;
         fl[1] = snan_a || snan_b;
      end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
         o = 32'h7FC00000;
         fl[1] = 1'b1;
      end else if (inf_a || inf_b) begin
         o = {s, 8'hFF, 23'h0};
      end else if (zero_a || zero_b) begin
         o = {s, 31'h0};
      end else begin
         ma   = (longint'(1) << 23) + longint'(a[22:0]);
         mb   = (longint'(1) << 23) + longint'(b[22:0]);
         p    = ma * mb;
         n    = (p >= (longint'(1) << 47)) ? 48 : 47;
         sh   = n - 24;
         q    = p >> sh;
         rem  = p - (q << sh);
         half = longint'(1) << (sh - 1);
         e    = ea + eb - 127 + (n - 47);
         case (rm)
            3'd1:    rup = 1'b0;
            3'd2:    rup = (rem != 0) && !s;
            3'd3:    rup = (rem != 0) && s;
            3'd4:    rup = (rem >= half);
            default: rup = (rem > half) || ((rem == half) && q[0]);
         endcase
         if (rup) q = q + 1;
         if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            fl = 4'b1001;
            if ((rm == 3'd1) || (rm == 3'd2 && s) || (rm == 3'd3 && !s)) o = {s, 8'hFE, 23'h7FFFFF};
            else o = {s, 8'hFF, 23'h0};
         end else if (e <= 0) begin
            fl = 4'b0101;
            o  = {s, 31'h0};
         end else begin
            o     = {s, e[7:0], q[22:0]};
            fl[0] = (rem != 0);
         end
      end
      return {tg, fl, o};
   endfunction

   function automatic logic [31:0] gen_op();
      logic [7:0]  e;
      logic [22:0] f;
      f = 23'($urandom);
      case ($urandom_range(0, 9))
         0: e = 8'h00;
         1: begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
         end
         2: e = 8'($urandom_range(1, 24));
         3: e = 8'($urandom_range(230, 254));
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, f};
   endfunction

   // One cycle of the streaming bench: check hold, drive, score accept/retire.
   task automatic step(input logic do_act, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [3:0] tg, input logic ordy,
                       output logic acc);
      logic [39:0] cur, exp_v;
      logic        present;
      @(negedge clk);
      cur = obs1();
      if (held_vld) chk("hold", {24'h0, cur}, {24'h0, held_val});
      b1.act = do_act; b1.in1 = a; b1.in2 = b; b1.round_m = rm; b1.tag_in = tg;
      b1.out_ready = ordy;
      #1;
      acc = do_act && b1.in_ready;
      if (acc) sb_q.push_back(ref_mul(a, b, rm, tg));
      if (b1.done && ordy) begin
         present = (sb_q.size() > 0);
         exp_v   = present ? sb_q.pop_front() : 40'h0;
         chk("result", {23'h0, 1'b1, cur}, {23'h0, present, exp_v});
         n_pop++;
      end
      held_vld = b1.done && !ordy;
      held_val = cur;
   endtask

   task automatic direct(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [31:0] eo, input logic [3:0] ef);
      logic [3:0] tg;
      int         lat;
      tg = 4'($urandom);
      @(negedge clk);
      b1.in1 = a; b1.in2 = b; b1.round_m = rm; b1.tag_in = tg; b1.act = 1'b1; b1.out_ready = 1'b1;
      @(negedge clk);
      b1.act = 1'b0;
      lat = 1;
      while (!b1.done && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, ".lat"},   64'(lat), 64'd3);
      chk({nm, ".out"},   64'(b1.out), 64'(eo));
      chk({nm, ".flags"}, 64'({b1.ov, b1.un, b1.inv, b1.inexact}), 64'(ef));
      chk({nm, ".tag"},   64'(b1.tag_out), 64'(tg));
      chk({nm, ".model"}, 64'(obs1()), 64'(ref_mul(a, b, rm, tg)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc, saw_stall;
      int          lat, idx, n_stale;
      logic [31:0] sa[8], sbb[8];
      logic [2:0]  srm[8];

      rst = 1'b0;
      held_vld = 1'b0;
      held_val = '0;
      b1.act = 0; b1.in1 = 0; b1.in2 = 0; b1.round_m = 0; b1.tag_in = 0; b1.out_ready = 0;
      bh.act = 0; bh.in1 = 0; bh.in2 = 0; bh.round_m = 0; bh.tag_in = 0; bh.out_ready = 1;
      #12;
      chk("rst.outs", 64'({b1.done, obs1()}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst.in_ready", 64'(b1.in_ready), 64'd1);

      direct("exact",    32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000);
      direct("rne_inx",  32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 4'b0001);
      direct("ru_inx",   32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 4'b0001);
      direct("rz_inx",   32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 4'b0001);
      direct("rd_neg",   32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800003, 4'b0001);
      direct("ovf_rne",  32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 4'b1001);
      direct("ovf_rz",   32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 4'b1001);
      direct("ovf_ru_n", 32'hFF000000, 32'h7F000000, 3'd2, 32'hFF7FFFFF, 4'b1001);
      direct("ovf_rna",  32'hFF000000, 32'h7F000000, 3'd4, 32'hFF800000, 4'b1001);
      direct("inf_zero", 32'h7F800000, 32'h80000000, 3'd0, 32'h7FC00000, 4'b0010);
      direct("snan",     32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 4'b0010);
      direct("qnan",     32'h3F800000, 32'hFFC00123, 3'd0, 32'h7FC00000, 4'b0000);
      direct("inf_fin",  32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 4'b0000);
      direct("negzero",  32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 4'b0000);
      direct("unf",      32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 4'b0101);
      direct("subn",     32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 4'b0000);

      // half-precision instance
      @(negedge clk);
      bh.in1 = 16'h3E00; bh.in2 = 16'h4000; bh.round_m = 3'd0; bh.tag_in = 4'h9; bh.act = 1'b1;
      @(negedge clk);
      bh.act = 1'b0;
      lat = 1;
      while (!bh.done && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("half.lat",   64'(lat), 64'd3);
      chk("half.out",   64'(bh.out), 64'h4200);
      chk("half.flags", 64'({bh.ov, bh.un, bh.inv, bh.inexact}), 64'd0);
      chk("half.tag",   64'(bh.tag_out), 64'h9);

      // 8 back-to-back ops with the sink stalled for cycles 4..9
      for (int i = 0; i < 8; i++) begin
         sa[i]  = gen_op();
         sbb[i] = gen_op();
         srm[i] = 3'($urandom_range(0, 4));
      end
      idx = 0;
      n_pop = 0;
      saw_stall = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step(idx < 8, sa[idx & 7], sbb[idx & 7], srm[idx & 7], 4'(idx), !(c >= 4 && c <= 9), acc);
         if (!b1.in_ready) saw_stall = 1'b1;
         if (acc) idx++;
      end
      chk("stream.accepted", 64'(idx), 64'd8);
      chk("stream.stall",    64'(saw_stall), 64'd1);
      chk("stream.count",    64'(n_pop), 64'd8);
      chk("stream.left",     64'(sb_q.size()), 64'd0);

      // randomized traffic with random back-pressure
      for (int c = 0; c < 600; c++)
         step($urandom_range(0, 3) != 0, gen_op(), gen_op(), 3'($urandom_range(0, 4)),
              4'($urandom), $urandom_range(0, 9) < 7, acc);
      for (int c = 0; c < 20 && sb_q.size() > 0; c++)
         step(1'b0, 32'h0, 32'h0, 3'd0, 4'h0, 1'b1, acc);
      chk("rand.drain", 64'(sb_q.size()), 64'd0);

      // reset with a full, stalled pipe
      for (int c = 0; c < 5; c++)
         step(1'b1, gen_op(), gen_op(), 3'd0, 4'(c), 1'b0, acc);
      chk("rst.pre_done", 64'(b1.done), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.mid_done", 64'(b1.done), 64'd0);
      sb_q.delete();
      held_vld = 1'b0;
      b1.act = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      n_stale = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 32'h0, 32'h0, 3'd0, 4'h0, 1'b1, acc);
         if (b1.done) n_stale++;
      end
      chk("rst.stale", 64'(n_stale), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
